regfile_scoreboard: RTL

- Parametrised multi-read-port register file for the R32 core pipeline.
- Adds same-cycle write-to-read bypass and an optional hardwired zero register.
- Adds a per-register pending (scoreboard) bit: set at instruction issue, cleared at writeback, used by decode for hazard stalls.
- Also exposes a registered pending-register count; a flush input drops all in-flight reservations.

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_scoreboard_if.sv | 49 ++++
 rtl/regfile_pending_tracker.sv | 84 ++++++++
 rtl/regfile_scoreboard.sv | 111 +++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and helpers for the R32 register file with pending
// scoreboard.
//   DATA_W_DEF / NUM_REGS_DEF / NUM_RD_DEF : default sizing of the file
//   reg_addr_t                             : register index at default size
//   popcount()                             : number of set bits in a vector
//                                            of up to POP_MAX_W bits
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    // Widest busy vector the file supports (NUM_REGS <= 64).
    localparam int POP_MAX_W    = 64;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    function automatic logic [6:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_if
// Pipeline-side bundle of the register file.
//   i_rd_sel / o_rd_data / o_rd_busy : NUM_RD packed read ports
//   i_wr_en / i_wr_sel / i_wr_data   : writeback
//   i_issue_en / i_issue_sel         : reserve a destination register
//   i_flush                          : drop every reservation
//   o_busy_vec / o_pending_cnt       : registered scoreboard state
// Modports: master = pipeline (drives i_*), slave = register file.
//
// Handshake semantics: there is no valid/ready back-pressure on this bundle.
// i_wr_en, i_issue_en and i_flush are single-cycle strobes, each sampled once
// at the rising clock edge; the register file always accepts them.
// -----------------------------------------------------------------------------
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(NUM_REGS + 1);

    logic [NUM_RD*ADDR_W-1:0] i_rd_sel;
    logic [NUM_RD*DATA_W-1:0] o_rd_data;
    logic [NUM_RD-1:0]        o_rd_busy;
    logic                     i_wr_en;
    logic [ADDR_W-1:0]        i_wr_sel;
    logic [DATA_W-1:0]        i_wr_data;
    logic                     i_issue_en;
    logic [ADDR_W-1:0]        i_issue_sel;
    logic                     i_flush;
    logic [NUM_REGS-1:0]      o_busy_vec;
    logic [CNT_W-1:0]         o_pending_cnt;

    modport master (
        output i_rd_sel, i_wr_en, i_wr_sel, i_wr_data,
               i_issue_en, i_issue_sel, i_flush,
        input  o_rd_data, o_rd_busy, o_busy_vec, o_pending_cnt
    );

    modport slave (
        input  i_rd_sel, i_wr_en, i_wr_sel, i_wr_data,
               i_issue_en, i_issue_sel, i_flush,
        output o_rd_data, o_rd_busy, o_busy_vec, o_pending_cnt
    );

endinterface

// File: rtl/regfile_pending_tracker.sv
// -----------------------------------------------------------------------------
// regfile_pending_tracker
// Per-register pending bits plus a registered count of them.
//   i_clock, i_reset         : clock, asynchronous active-high reset
//   i_wr_en, i_wr_sel        : writeback clears the destination's bit
//   i_issue_en, i_issue_sel  : issue sets the destination's bit
//   i_flush                  : clears every bit not being issued this cycle
//   o_busy_vec               : registered pending bits
//   o_pending_cnt            : registered popcount of o_busy_vec
// Edge priority: issue > flush > writeback.
// -----------------------------------------------------------------------------
module regfile_pending_tracker
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int CNT_W   = $clog2(NUM_REGS + 1)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_sel,
    input  logic                i_issue_en,
    input  logic [ADDR_W-1:0]   i_issue_sel,
    input  logic                i_flush,
    output logic [NUM_REGS-1:0] o_busy_vec,
    output logic [CNT_W-1:0]    o_pending_cnt
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 issue_ok;
    logic                 set_inc;
    logic                 clr_dec;
    logic [POP_MAX_W-1:0] pop_in;

    always_comb begin
        issue_ok = i_issue_en && !(ZERO_EN && (i_issue_sel == '0));
        busy_d   = busy_q;
        pop_in   = '0;

        // Lower priority first so the issue assignment below wins.
        if (i_flush) begin
            busy_d = '0;
        end else if (i_wr_en) begin
            busy_d[i_wr_sel] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[i_issue_sel] = 1'b1;
        end

        // Incremental count: +1 when a clear bit gets set, -1 when a set bit
        // is released by writeback and not re-claimed by an issue to the same
        // register in the same cycle.
        set_inc = issue_ok && !busy_q[i_issue_sel];
        clr_dec = i_wr_en && busy_q[i_wr_sel] &&
                  !(issue_ok && (i_issue_sel == i_wr_sel));

        if (i_flush) begin
            // Flush reloads from the surviving vector (0 or 1 bits set).
            pop_in[NUM_REGS-1:0] = busy_d;
            cnt_d = CNT_W'(popcount(pop_in));
        end else begin
            cnt_d = cnt_q + CNT_W'(set_inc) - CNT_W'(clr_dec);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_busy_vec    = busy_q;
    assign o_pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Multi-read-port register file with write-to-read bypass, optional hardwired
// zero register and a pending-register scoreboard.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   bus (slave)      : read ports, writeback, issue, flush, scoreboard outputs
// Build option REGFILE_SYNC_READ_EN: when defined, read data and read busy are
// registered (one cycle latency, write-first); when undefined reads are
// combinational. Scoreboard timing is the same in both builds.
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    regfile_scoreboard_if.slave  bus
);

    localparam int ADDR_W  = $clog2(NUM_REGS);
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0]        mem_q [NUM_REGS];
    logic                     wr_ok;
    logic [NUM_REGS-1:0]      busy_vec;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    // Writes to the zero register are dropped.
    assign wr_ok = bus.i_wr_en && !(ZERO_EN && (bus.i_wr_sel == '0));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[bus.i_wr_sel] <= bus.i_wr_data;
        end
    end

    regfile_pending_tracker #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_tracker (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_wr_en       (bus.i_wr_en),
        .i_wr_sel      (bus.i_wr_sel),
        .i_issue_en    (bus.i_issue_en),
        .i_issue_sel   (bus.i_issue_sel),
        .i_flush       (bus.i_flush),
        .o_busy_vec    (busy_vec),
        .o_pending_cnt (bus.o_pending_cnt)
    );

    assign bus.o_busy_vec = busy_vec;

    // Bypass muxes: a writeback in flight is forwarded and also masks the
    // busy bit, since the value on i_wr_data is the one the reader waits for.
    always_comb begin : rd_mux
        logic [ADDR_W-1:0] sel;
        logic              hit;
        rd_data_c = '0;
        rd_busy_c = '0;
        sel       = '0;
        hit       = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            sel = bus.i_rd_sel[k*ADDR_W +: ADDR_W];
            hit = bus.i_wr_en && (bus.i_wr_sel == sel);
            if (ZERO_EN && (sel == '0)) begin
                rd_data_c[k*DATA_W +: DATA_W] = '0;
            end else if (hit) begin
                rd_data_c[k*DATA_W +: DATA_W] = bus.i_wr_data;
            end else begin
                rd_data_c[k*DATA_W +: DATA_W] = mem_q[sel];
            end
            rd_busy_c[k] = busy_vec[sel] & ~hit;
        end
    end

`ifdef REGFILE_SYNC_READ_EN
    // Registering the bypassed value makes the read stage write-first.
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    assign rd_data_d = rd_data_c;
    assign rd_busy_d = rd_busy_c;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.o_rd_data = rd_data_q;
    assign bus.o_rd_busy = rd_busy_q;
`else
    assign bus.o_rd_data = rd_data_c;
    assign bus.o_rd_busy = rd_busy_c;
`endif

endmodule
